// File: rtl/sumador_serial_nbits_pkg.sv
// Shared state encoding for the bit-serial adder/subtractor.
package sumador_serial_nbits_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sumador_serial_nbits_if.sv
// Operation request/result bundle between the sequencing controller and the serial adder.
interface sumador_serial_nbits_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Ci;
    logic         sub;
    logic [N-1:0] S;
    logic         Co;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, Ci, sub,
        input  S, Co, overflow, busy, done
    );

    modport slave (
        input  start, A, B, Ci, sub,
        output S, Co, overflow, busy, done
    );
endinterface

// File: rtl/sumador_1bit.sv
// Combinational full-adder cell.
module sumador_1bit (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));
endmodule

// File: rtl/sumador_serial_nbits.sv
// Bit-serial N-bit adder/subtractor: one full-adder cell and a carry flip-flop, LSB first.
import sumador_serial_nbits_pkg::*;

module sumador_serial_nbits #(
    parameter  int N     = 8,
    localparam int CNT_W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    sumador_serial_nbits_if.slave  bus
);
    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_a_sh;
    logic [N-1:0]       r_b_sh;
    logic [N-1:0]       r_res;
    logic [N-1:0]       r_s;
    logic               r_carry;
    logic               r_cin_msb;
    logic               r_co;
    logic               r_ovf;
    logic               r_done;
    logic               w_s;
    logic               w_c;
    logic               w_accept;
    logic               w_last;

    sumador_1bit u_cell (
        .A  (r_a_sh[0]),
        .B  (r_b_sh[0]),
        .Ci (r_carry),
        .S  (w_s),
        .Co (w_c)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res     <= '0;
            r_s       <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_co      <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            // Subtraction runs as A + ~B + ~Ci, so Co=1 means no borrow.
            if (w_accept) begin
                r_a_sh  <= bus.A;
                r_b_sh  <= bus.B ^ {N{bus.sub}};
                r_carry <= bus.Ci ^ bus.sub;
                r_cnt   <= '0;
                r_res   <= '0;
            end else if (r_state == ST_RUN) begin
                r_res   <= {w_s, r_res[N-1:1]};
                r_a_sh  <= {1'b0, r_a_sh[N-1:1]};
                r_b_sh  <= {1'b0, r_b_sh[N-1:1]};
                r_carry <= w_c;
                if (w_last) begin
                    r_cin_msb <= r_carry;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (r_state == ST_DONE) begin
                r_s   <= r_res;
                r_co  <= r_carry;
                r_ovf <= r_cin_msb ^ r_carry;
            end
        end
    end

    assign bus.S        = r_s;
    assign bus.Co       = r_co;
    assign bus.overflow = r_ovf;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
endmodule

// File: tb/tb_sumador_serial_nbits.sv
// Self-checking bench: scoreboarded N=8 vectors and handshake cases, plus exhaustive N=4 sweep.
module tb_sumador_serial_nbits;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sumador_serial_nbits_if #(.N(8)) bus8 ();
    sumador_serial_nbits_if #(.N(4)) bus4 ();

    sumador_serial_nbits #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sumador_serial_nbits #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   mcnt   = 0;
    exp_t sbq[$];
    logic       use_tab = 1'b0;
    logic [7:0] tab_s   = '0;
    logic       tab_co  = 1'b0;
    logic       tab_ov  = 1'b0;

    function automatic exp_t model8(logic [7:0] a, logic [7:0] b, logic ci, logic sub);
        exp_t       e;
        logic [7:0] bx;
        logic [8:0] sum;
        bx    = b ^ {8{sub}};
        sum   = {1'b0, a} + {1'b0, bx} + {8'd0, ci ^ sub};
        e.s   = sum[7:0];
        e.co  = sum[8];
        e.ov  = (a[7] == bx[7]) && (sum[7] != a[7]);
        e.due = 0;
        return e;
    endfunction

    // Acceptance model: predicts when the DUT takes a start and when done is due.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt <= 0;
            sbq.delete();
        end else begin
            cyc <= cyc + 1;
            if (mcnt == 0 && bus8.start) begin
                exp_t e;
                if (use_tab) begin
                    e.s = tab_s; e.co = tab_co; e.ov = tab_ov;
                end else begin
                    e = model8(bus8.A, bus8.B, bus8.Ci, bus8.sub);
                end
                e.due = cyc + 1 + N + 1;
                sbq.push_back(e);
                mcnt <= N + 1;
            end else if (mcnt > 0) begin
                mcnt <= mcnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus8.busy !== (mcnt != 0)) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus8.busy, (mcnt != 0));
            end
            if (bus8.done === 1'b1) begin
                checks++;
                if (sbq.size() == 0 || sbq[0].due != cyc) begin
                    errors++;
                    $display("FAIL done_unexpected cyc=%0d got=1 want=0", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (bus8.S !== e.s || bus8.Co !== e.co || bus8.overflow !== e.ov) begin
                        errors++;
                        $display("FAIL result cyc=%0d got S=%h Co=%b ov=%b want S=%h Co=%b ov=%b",
                                 cyc, bus8.S, bus8.Co, bus8.overflow, e.s, e.co, e.ov);
                    end
                end
            end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
                checks++;
                errors++;
                $display("FAIL done_missing cyc=%0d got=%b want=1", cyc, bus8.done);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && (sbq.size() != 0 || mcnt != 0); i++) @(negedge clk);
        if (sbq.size() != 0 || mcnt != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d want=0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic start_op(logic [7:0] a, logic [7:0] b, logic ci, logic sub);
        @(negedge clk);
        bus8.A = a; bus8.B = b; bus8.Ci = ci; bus8.sub = sub;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.A = ~a; bus8.B = ~b; bus8.Ci = ~ci; bus8.sub = ~sub;
    endtask

    task automatic check_val(string name, logic [15:0] got, logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Ci = 1'b0; bus8.sub = 1'b0;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Ci = 1'b0; bus4.sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset8", {bus8.S, 4'd0, bus8.Co, bus8.overflow, bus8.busy, bus8.done}, 16'h0000);
        check_val("reset4", {8'd0, bus4.S, bus4.Co, bus4.overflow, bus4.busy, bus4.done}, 16'h0000);

        use_tab = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tab_s = vecs[i].s; tab_co = vecs[i].co; tab_ov = vecs[i].ov;
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
            wait_idle();
        end
        use_tab = 1'b0;

        // start held high with operands changing every cycle
        @(negedge clk);
        bus8.start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus8.A = 8'($urandom); bus8.B = 8'($urandom);
            bus8.Ci = 1'($urandom); bus8.sub = 1'($urandom);
            @(negedge clk);
        end
        bus8.start = 1'b0;
        wait_idle();

        // reset aborts a running operation; S holds old value during RUN
        start_op(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_idle();
        start_op(8'h33, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        check_val("s_held_in_run", {8'd0, bus8.S}, 16'h0010);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset_mid_run", {bus8.S, 4'd0, bus8.Co, bus8.overflow, bus8.busy, bus8.done}, 16'h0000);
        repeat (N + 3) @(negedge clk);
        start_op(8'h12, 8'h34, 1'b1, 1'b0);
        wait_idle();

        // N=4 exhaustive sweep against a local reference
        @(negedge clk);
        for (int v = 0; v < 1024; v++) begin
            logic [3:0] a, b, bx;
            logic       ci, sub, got_done;
            logic [4:0] sum;
            logic       ov;
            int         lat;
            a = 4'(v); b = 4'(v >> 4); ci = 1'(v >> 8); sub = 1'(v >> 9);
            bx  = b ^ {4{sub}};
            sum = {1'b0, a} + {1'b0, bx} + {4'd0, ci ^ sub};
            ov  = (a[3] == bx[3]) && (sum[3] != a[3]);
            bus4.A = a; bus4.B = b; bus4.Ci = ci; bus4.sub = sub; bus4.start = 1'b1;
            @(negedge clk);
            bus4.start = 1'b0;
            got_done = 1'b0;
            lat = 0;
            for (int i = 1; i <= 10 && !got_done; i++) begin
                @(negedge clk);
                if (bus4.done === 1'b1) begin
                    got_done = 1'b1;
                    lat = i;
                end
            end
            checks++;
            if (!got_done || lat != 5 || bus4.S !== sum[3:0] || bus4.Co !== sum[4] || bus4.overflow !== ov) begin
                errors++;
                $display("FAIL n4 a=%h b=%h ci=%b sub=%b got lat=%0d S=%h Co=%b ov=%b want lat=5 S=%h Co=%b ov=%b",
                         a, b, ci, sub, lat, bus4.S, bus4.Co, bus4.overflow, sum[3:0], sum[4], ov);
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end
endmodule
